// File: rtl/caph_fifo_pkg.sv
// caph_fifo_pkg
//   Shared definitions for the CAPH channel FIFO: the default token width and
//   depth of a channel, and the encoding of which side is accepted in a cycle.
//   No ports (package).
package caph_fifo_pkg;

  // Default token width of a CAPH channel.
  localparam int CAPH_DATA_WIDTH = 16;

  // Default number of token slots in a channel.
  localparam int CAPH_DEPTH = 4;

  // Which side of the channel is accepted on a clock edge, as {write, read}.
  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_RD   = 2'b01,
    ACC_WR   = 2'b10,
    ACC_BOTH = 2'b11
  } acc_e;

endpackage : caph_fifo_pkg

// File: rtl/caph_fifo_if.sv
// caph_fifo_if
//   Groups the producer and consumer handshake of one CAPH channel.
//   Signals:
//     din   producer token            wr    producer write request
//     full  no free slot              dout  head token (valid when !empty)
//     rd    consumer pop request      empty no token held
//     count occupancy 0..DEPTH        ovf   sticky write-while-full
//     udf   sticky read-while-empty
//   Modports:
//     slave  - the FIFO itself
//     master - the actors (producer and consumer) around it
interface caph_fifo_if
  import caph_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = CAPH_DATA_WIDTH,
  parameter int DEPTH      = CAPH_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] din;
  logic                  wr;
  logic                  full;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd;
  logic                  empty;
  logic [AW:0]           count;
  logic                  ovf;
  logic                  udf;

  modport slave (
    input  din, wr, rd,
    output full, dout, empty, count, ovf, udf
  );

  modport master (
    output din, wr, rd,
    input  full, dout, empty, count, ovf, udf
  );

endinterface : caph_fifo_if

// File: rtl/caph_fifo_mem.sv
// caph_fifo_mem
//   DEPTH x DATA_WIDTH token store for caph_fifo. Kept separate so it can be
//   mapped onto distributed RAM later. Contents are deliberately not reset.
//   Ports:
//     i_clk   clock, rising edge
//     i_we    write enable
//     i_waddr write slot
//     i_wdata write token
//     i_raddr read slot (asynchronous read)
//     o_rdata token at i_raddr
module caph_fifo_mem
  import caph_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = CAPH_DATA_WIDTH,
  parameter int DEPTH      = CAPH_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read port: the head token is visible without a wait state.
  assign o_rdata = r_mem[i_raddr];

endmodule : caph_fifo_mem

// File: rtl/caph_fifo.sv
// caph_fifo
//   Point-to-point first-word-fall-through FIFO channel between two CAPH
//   actors. Pointers, occupancy and sticky error flags live here; the token
//   store is caph_fifo_mem. Every output is a function of registered state
//   only, so no combinational path runs from wr/rd/din to any output.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous active-low reset
//     ch     channel interface (slave side): din/wr/full from the producer,
//            dout/rd/empty to the consumer, plus count/ovf/udf status
module caph_fifo
  import caph_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = CAPH_DATA_WIDTH,
  parameter int DEPTH      = CAPH_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  caph_fifo_if.slave  ch
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO  = '0;
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  acc_e                  w_acc;
  logic [AW:0]           w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Flags come from the registered count, never from the requests.
  assign w_full  = (r_count == CNT_DEPTH);
  assign w_empty = (r_count == CNT_ZERO);

  // A full FIFO still accepts a read; an empty one still accepts a write.
  assign w_wr_acc = ch.wr & ~w_full;
  assign w_rd_acc = ch.rd & ~w_empty;
  assign w_acc    = acc_e'({w_wr_acc, w_rd_acc});

  // Occupancy change for this edge.
  always_comb begin
    w_count_nxt = r_count;
    case (w_acc)
      ACC_WR:   w_count_nxt = r_count + CNT_ONE;
      ACC_RD:   w_count_nxt = r_count - CNT_ONE;
      ACC_BOTH: w_count_nxt = r_count;
      ACC_NONE: w_count_nxt = r_count;
      default:  w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and sticky error flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_ovf   <= r_ovf | (ch.wr & w_full);
      r_udf   <= r_udf | (ch.rd & w_empty);
    end
  end

  caph_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (ch.din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign ch.full  = w_full;
  assign ch.empty = w_empty;
  assign ch.count = r_count;
  assign ch.ovf   = r_ovf;
  assign ch.udf   = r_udf;
  // Head token straight from the store; meaningless while empty.
  assign ch.dout  = w_rdata;

endmodule : caph_fifo

// File: tb/tb_caph_fifo.sv
// tb_caph_fifo
//   Self-checking bench for caph_fifo. A queue-based reference model of the
//   channel supplies every expected value. A second pair of FIFOs joined by a
//   shift-left actor exercises back-pressure in a loopback.
module tb_caph_fifo;
  import caph_fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;

  int vectors;
  int miscompares;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic          m_udf;

  caph_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ch ();
  caph_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) lb_a ();
  caph_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) lb_b ();

  caph_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .ch    (ch)
  );

  caph_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut_a (
    .clock (clock),
    .reset (reset),
    .ch    (lb_a)
  );

  caph_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut_b (
    .clock (clock),
    .reset (reset),
    .ch    (lb_b)
  );

  // Combinational shift-left actor: fires when it has a token and room.
  assign lb_a.rd  = ~lb_a.empty & ~lb_b.full;
  assign lb_b.wr  = ~lb_a.empty & ~lb_b.full;
  assign lb_b.din = {lb_a.dout[DW-2:0], 1'b0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Compare every defined output of the main DUT with the model.
  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(ch.count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(ch.empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(ch.full),  32'(mq.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ch.ovf),   32'(m_ovf));
    chk({tag, ".udf"},   32'(ch.udf),   32'(m_udf));
    if (mq.size() != 0) begin
      chk({tag, ".dout"}, 32'(ch.dout), 32'(mq[0]));
    end
  endtask

  // One clock: apply requests, let the edge pass, update the model, check.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
    int sz;
    ch.wr  = w;
    ch.din = d;
    ch.rd  = r;
    @(posedge clock);
    sz = mq.size();
    if (w && sz == DEPTH) m_ovf = 1'b1;
    if (r && sz == 0)     m_udf = 1'b1;
    if (r && sz > 0)      void'(mq.pop_front());
    if (w && sz < DEPTH)  mq.push_back(d);
    #1;
    ch.wr = 1'b0;
    ch.rd = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] lb_in[$];
    logic [DW-1:0] lb_exp[$];
    int            n_tok;
    int            tx;
    int            rx;
    logic          pw;
    logic          pr;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    ch.wr       = 1'b0;
    ch.rd       = 1'b0;
    ch.din      = '0;
    lb_a.wr     = 1'b0;
    lb_a.din    = '0;
    lb_b.rd     = 1'b0;
    model_reset();

    // Reset state.
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;

    // Fill with 1..4, then one write too many.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, "fill");
    chk("fill_full", 32'(ch.full), 32'd1);
    cyc(1'b1, 16'h0005, 1'b0, "ovf_write");
    chk("ovf_set", 32'(ch.ovf), 32'd1);

    // Drain: dout order 1..4, never the dropped 5.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 16'h0000, 1'b1, "drain");
    chk("drain_empty", 32'(ch.empty), 32'd1);

    // Read while empty.
    cyc(1'b0, 16'h0000, 1'b1, "udf_read");
    chk("udf_set", 32'(ch.udf), 32'd1);

    // Reset mid-run with three tokens held: clears everything at once.
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'h0100 + i), 1'b0, "pre_rst");
    chk("pre_rst_count", 32'(ch.count), 32'd3);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b1;

    // First token after reset appears one cycle after its write edge.
    cyc(1'b1, 16'h00AA, 1'b0, "post_rst");
    chk("post_rst_dout", 32'(ch.dout), 32'h00AA);

    // Count of two, then simultaneous write+read across pointer wrap.
    cyc(1'b1, 16'h00AB, 1'b0, "to_two");
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(16'h0200 + i), 1'b1, "wr_rd");
    chk("wr_rd_count", 32'(ch.count), 32'd2);

    // Full with write+read: read wins, write dropped.
    cyc(1'b1, 16'h0300, 1'b0, "to_full");
    cyc(1'b1, 16'h0301, 1'b0, "to_full");
    cyc(1'b1, 16'h0302, 1'b1, "full_wr_rd");
    chk("full_wr_rd_count", 32'(ch.count), 32'd3);
    cyc(1'b1, 16'h0303, 1'b0, "freed_slot");

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    // Loopback through the shift-left actor under random back-pressure.
    lb_in.push_back(16'h0003);
    lb_in.push_back(16'h4001);
    lb_in.push_back(16'h8000);
    for (int i = 0; i < 20; i++) lb_in.push_back(DW'($urandom));
    foreach (lb_in[i]) lb_exp.push_back({lb_in[i][DW-2:0], 1'b0});
    n_tok = lb_in.size();
    tx    = 0;
    rx    = 0;
    for (int c = 0; c < 2000 && rx < n_tok; c++) begin
      pw = (tx < n_tok) && !lb_a.full && ($urandom_range(0, 2) != 0);
      pr = !lb_b.empty && ($urandom_range(0, 2) == 0);
      lb_a.wr  = pw;
      lb_a.din = pw ? lb_in[tx] : '0;
      lb_b.rd  = pr;
      if (pr) begin
        chk("lb_dout", 32'(lb_b.dout), 32'(lb_exp[rx]));
        rx++;
      end
      @(posedge clock);
      if (pw) tx++;
      #1;
    end
    lb_a.wr = 1'b0;
    lb_b.rd = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("lb_rx_total", 32'(rx), 32'(n_tok));
    chk("lb_b_empty", 32'(lb_b.empty), 32'd1);
    chk("lb_a_empty", 32'(lb_a.empty), 32'd1);
    chk("lb_ovf", 32'({lb_a.ovf, lb_b.ovf}), 32'd0);
    chk("lb_udf", 32'({lb_a.udf, lb_b.udf}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_caph_fifo

// File: doc/caph_fifo.md
Name: caph_fifo

Overview:
- Point-to-point FIFO channel between two CAPH actors.
- Producer side: the producer actor drives `wr`/`din` and watches `full`.
- Consumer side: the consumer actor watches `empty`, samples `dout` and pulses `rd` in the same cycle.
- Read side is first-word-fall-through (FWFT). When `empty`=0, `dout` already carries the head token, so a combinational consumer can read and use it without a wait state.

Parameters:
- DATA_WIDTH, 16, token width in bits.
- DEPTH, 4, number of token slots; must be a power of two and ≥2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  write token from producer.
- wr  in  1  write request (producer's out_wr).
- full  out  1  no free slot (to producer's out_full).
- dout  out  DATA_WIDTH  head token, valid when `empty`=0 (to consumer's in).
- rd  in  1  read/pop request (consumer's in_rd).
- empty  out  1  no token held (to consumer's in_empty).
- count  out  AW+1  occupancy, 0..DEPTH.
- ovf  out  1  sticky: write attempted while full.
- udf  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (`reset`=0, asynchronous assert, synchronous release):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, ovf=0, udf=0.
  - Storage array is not reset.
- Write/read acceptance:
  - Write accepted iff wr=1 and full=0. Stores din at mem[wr_ptr] and advances wr_ptr modulo DEPTH.
  - Read accepted iff rd=1 and empty=0. Advances rd_ptr modulo DEPTH.
- Pointer wrap: natural AW-bit overflow, DEPTH-1 → 0.
- count updates on each rising edge:
  - +1 on a write-only accept.
  - −1 on a read-only accept.
  - Unchanged when both accept or neither accepts.
- Flags: empty = (count==0) and full = (count==DEPTH), both derived from the registered count.
- dout = mem[rd_ptr], combinational from registered state.
  - Value is don't-care while empty=1; the bench must not check it then.
  - No write-to-read bypass: a token written into an empty FIFO appears at dout, with empty=0, in the cycle after the write edge. Write-to-read latency is 1 cycle.
- Simultaneous events:
  - wr & rd, 0<count<DEPTH: both accepted, count unchanged.
  - wr & rd, count==0: write accepted, read rejected; udf set.
  - wr & rd, count==DEPTH: read accepted, write rejected; ovf set. The slot freed by this read is usable from the next cycle.
- Error flags:
  - ovf set on any edge with wr=1 & full=1.
  - udf set on any edge with rd=1 & empty=1.
  - Both are cleared only by reset. A rejected request changes no other state.
- Reset mid-operation: all state returns to reset values asynchronously. Tokens in flight are discarded, and the first post-reset write lands in slot 0.
- No combinational path from wr/rd/din to any output. All outputs are functions of registered state.
- The X-default style of combinational actors on their outputs must not propagate here: every output is defined whenever reset is released, except dout while empty.

Decomposition:
- No shared package required; AW is local to the module.
- If a channel package already exists, DATA_WIDTH default token width goes there.
- One natural sub-module, caph_fifo_mem:
  - DEPTH×DATA_WIDTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr → rdata).
  - Separated so it can later be mapped to distributed RAM.
- Pointer, count and flag logic stay in caph_fifo.

Test Plan:
- Reset/idle: assert reset=0 mid-run with count=3 → empty=1, full=0, count=0, ovf=udf=0 immediately. After release, write 0x00AA → dout=0x00AA one cycle later.
- Fill/drain, DEPTH=4:
  - Write 0x0001..0x0004 on consecutive cycles with rd=0 → full=1, count=4 after 4th edge.
  - Then rd=1 for 4 cycles → dout sequence 0x0001,0x0002,0x0003,0x0004; empty=1 after 4th edge.
- Overflow/underflow:
  - 5th write 0x0005 while full → ovf=1, count stays 4, later reads never return 0x0005.
  - rd while empty → udf=1, count stays 0.
- Simultaneous:
  - With count=2, wr+rd for 10 cycles with incrementing din → count stays 2 and dout order is preserved across pointer wrap.
  - At count=4 with wr+rd → read accepted, write dropped, ovf=1, count=3.
- Actor loopback: connect a combinational shift-left-by-1 actor between two caph_fifo instances, push 0x0003,0x4001,0x8000 → output FIFO yields 0x0006,0x8002,0x0000. Random full/empty back-pressure must give no loss or duplication.
